line_clear_ctrl: RTL
====================

LINE_CLEAR_CTRL -- requirements
Module: line_clear_ctrl

Interface
REQ-001 SHALL use parameters: COLS, default 10, board width in cells; ROWS, default 20, board height in cells.
REQ-002 SHALL have ports:
- CLOCK_50, input, 1, system clock.
- resetn, input, 1, reset.
- start, input, 1, request to scan and clear the board.
- busy, output, 1, operation in progress.
- done, output, 1, one-cycle completion pulse.
- lines_cleared, output, 3, number of rows removed by the last operation.
- board_rx, output, 4, read column address.
- board_ry, output, 5, read row address.
- board_rdata, input, 1, occupancy of the read cell; valid one cycle after the address is presented.
- board_we, output, 1, one-cycle write enable.
- board_wx, output, 4, write column address.
- board_wy, output, 5, write row address.
- board_wdata, output, 1, write data (1 = occupied).
REQ-003 SHALL use reset resetn, synchronous, active-low; clock CLOCK_50.

Function
REQ-004 SHALL implement states IDLE, SCAN, EVAL, SHIFT_RD, SHIFT_WR, CLR_TOP, DONE.
REQ-005 IDLE: start=1 SHALL clear lines_cleared, set row pointer r=ROWS-1 and column counter x=0, and go to SCAN; start=0 SHALL keep the block in IDLE.
REQ-006 start SHALL be ignored in every state except IDLE, including DONE.
REQ-007 busy SHALL be 1 in every state except IDLE.
REQ-008 SCAN SHALL last exactly COLS+1 cycles per row. Cycle k (0..COLS-1) presents board_rx=k, board_ry=r. Cycles 1..COLS AND board_rdata into a row_full flag, which is set to 1 on SCAN entry.
REQ-009 SCAN SHALL NOT exit early on an empty cell.
REQ-010 EVAL, one cycle:
- row_full=1: lines_cleared increments, saturating at 7. If r=0, go to CLR_TOP; else go to SHIFT_RD with y=r, x=0.
- row_full=0 and r>0: decrement r and re-enter SCAN.
- row_full=0 and r=0: go to DONE.
REQ-011 SHIFT_RD SHALL present board_rx=x, board_ry=y-1, then go to SHIFT_WR.
REQ-012 SHIFT_WR SHALL assert board_we=1 with board_wx=x, board_wy=y, board_wdata=board_rdata. It then advances in column-major order: x+1; at x=COLS-1 wrap x to 0 and decrement y. When y reaches 0, go to CLR_TOP with x=0; otherwise return to SHIFT_RD.
REQ-013 CLR_TOP SHALL write board_wdata=0 to row 0, columns 0..COLS-1, one cell per cycle (COLS cycles). It then re-enters SCAN on the same r; r is not decremented.
REQ-014 board_we SHALL be 1 only in SHIFT_WR and CLR_TOP. board_w* and board_r* values are don't-care when not in use, but SHALL never exceed COLS-1 / ROWS-1.
REQ-015 DONE SHALL assert done=1 for exactly one cycle, hold lines_cleared, then go to IDLE.
REQ-016 lines_cleared SHALL hold its value in IDLE until the next accepted start.
REQ-017 Timing:
- A non-full row costs COLS+2 cycles (SCAN+EVAL).
- Clearing row r costs 2·COLS·r + COLS cycles before the rescan.
- An empty default board gives done on cycle 241 after the start cycle (start sampled at cycle 0).
REQ-018 The only arithmetic on r, y and x SHALL be bounded decrements and increments. No wrap below 0 or above the maximum SHALL occur.

Reset
REQ-019 resetn=0 at a clock edge SHALL force IDLE with busy=0, done=0, board_we=0, lines_cleared=0, and r, x, y and row_full zeroed.
REQ-020 Reset mid-operation SHALL abort immediately with no further writes. Board contents already written are not restored.

Verification
REQ-021 The bench SHALL cover the following scenarios:
- Empty 10x20 board, start pulse -> board_we never asserted; done on cycle 241; lines_cleared=0; busy high cycles 1..241.
- Row 19 full, all other rows empty -> exactly 200 writes (190 shift + 10 top clear); final board empty; lines_cleared=1.
- Rows 18,19 full plus cell (3,17) set -> final board holds only (3,19); lines_cleared=2.
- Row 19 with 9 cells set ((9,19) clear) -> no writes; board unchanged; lines_cleared=0.
- Rows 16..19 full -> final board empty; lines_cleared=4. A start pulse issued while busy is ignored: exactly one done pulse results.
- resetn low during SHIFT_WR -> next cycle busy=0, board_we=0, done=0, lines_cleared=0. A subsequent start then runs normally.

Source files
------------

// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: scans the board bottom-up, removes full rows by shifting everything above down one row,
// then blanks row 0 and rescans the same row until no full row remains.
module line_clear_ctrl #(
  parameter int COLS = 10,
  parameter int ROWS = 20
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [2:0] lines_cleared,
  output logic [3:0] board_rx,
  output logic [4:0] board_ry,
  input  logic       board_rdata,
  output logic       board_we,
  output logic [3:0] board_wx,
  output logic [4:0] board_wy,
  output logic       board_wdata
);
  localparam logic [2:0] IDLE = 3'd0, SCAN = 3'd1, EVAL = 3'd2, SHIFT_RD = 3'd3,
                         SHIFT_WR = 3'd4, CLR_TOP = 3'd5, DONE = 3'd6;
  localparam logic [3:0] XMAX = 4'(COLS - 1);
  localparam logic [3:0] XEND = 4'(COLS);
  localparam logic [4:0] RMAX = 5'(ROWS - 1);
  logic [2:0] state;
  logic [3:0] x;
  logic [4:0] r, y;
  logic       row_full;
  logic [2:0] lc;
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state    <= IDLE;
      x        <= '0;
      y        <= '0;
      r        <= '0;
      row_full <= 1'b0;
      lc       <= '0;
    end else begin
      case (state)
        IDLE:
          if (start) begin
            lc       <= '0;
            r        <= RMAX;
            x        <= '0;
            row_full <= 1'b1;
            state    <= SCAN;
          end
        SCAN: begin
          // read data lags the address by one cycle, so cycle 0 carries nothing
          if (x != 4'd0) row_full <= row_full & board_rdata;
          if (x == XEND) state <= EVAL;
          else x <= x + 4'd1;
        end
        EVAL:
          if (row_full) begin
            lc    <= (lc == 3'd7) ? lc : lc + 3'd1;
            x     <= '0;
            y     <= r;
            state <= (r == 5'd0) ? CLR_TOP : SHIFT_RD;
          end else if (r != 5'd0) begin
            r        <= r - 5'd1;
            x        <= '0;
            row_full <= 1'b1;
            state    <= SCAN;
          end else state <= DONE;
        SHIFT_RD: state <= SHIFT_WR;
        SHIFT_WR:
          if (x == XMAX) begin
            x     <= '0;
            y     <= y - 5'd1;
            state <= (y == 5'd1) ? CLR_TOP : SHIFT_RD;
          end else begin
            x     <= x + 4'd1;
            state <= SHIFT_RD;
          end
        CLR_TOP:
          if (x == XMAX) begin
            x        <= '0;
            row_full <= 1'b1;
            state    <= SCAN;
          end else x <= x + 4'd1;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign busy          = state != IDLE;
  assign done          = state == DONE;
  assign lines_cleared = lc;
  assign board_we      = (state == SHIFT_WR) || (state == CLR_TOP);
  assign board_rx      = (x > XMAX) ? XMAX : x;
  assign board_ry      = (state == SHIFT_RD) ? y - 5'd1 : r;
  assign board_wx      = (x > XMAX) ? XMAX : x;
  assign board_wy      = (state == CLR_TOP) ? 5'd0 : y;
  assign board_wdata   = (state == SHIFT_WR) & board_rdata;
endmodule
